tx_frame_arbiter: RTL and testbench
===================================

Name: tx_frame_arbiter

Overview:
Shares the single TX MAC byte interface between two frame sources, e.g. bridge port A and port B egress buffers. Each frame is granted in round-robin order and its bytes are passed to the MAC with a valid/ready handshake. The block generates mac_last_o, pads short frames to the Ethernet minimum and enforces an inter-frame gap. It sits between the per-port TX control/buffer blocks and the MAC.

Parameters:
LEN_W, 16, width of the frame length field in bytes
MIN_LEN, 60, minimum frame length without FCS; shorter frames are padded when padding is enabled
IFG_CYCLES, 12, idle clk cycles forced between frames

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_i  in  2  per-channel frame request; level, sampled only in IDLE
len_i  in  2*LEN_W  per-channel frame length; ch0 is [LEN_W-1:0]; latched at grant
data_i  in  16  per-channel byte; ch0 is [7:0]
valid_i  in  2  per-channel byte valid
ready_o  out  2  per-channel byte accept; only the granted bit can be 1
grant_o  out  2  one-hot; held high for the whole frame including PAD
done_o  out  2  one-cycle pulse per channel when its frame completes
mac_data_o  out  8  byte to MAC
mac_valid_o  out  1  byte valid to MAC
mac_last_o  out  1  final byte of frame, qualified by mac_valid_o
mac_ready_i  in  1  MAC accepts byte
busy_o  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, SEND, PAD, IFG. Reset sets state IDLE, rr pointer=ch0, byte counter=0.
- Reset values: grant_o, done_o, ready_o, mac_valid_o, mac_last_o and busy_o are 0; mac_data_o is 8'h00.
- IDLE arbitration:
  - If only one req_i bit is set, grant that channel.
  - If both are set, grant the channel the rr pointer names.
  - Registered grant: grant_o rises the cycle after the request is seen.
  - len_i of the granted channel is latched. Next state is SEND.
- Zero-length request (len==0, padding disabled): done_o pulses in the grant cycle. No MAC traffic. Next state is IFG.
- SEND datapath: zero-latency combinational mux from the granted channel.
  - mac_data_o = data_i[sel]
  - mac_valid_o = valid_i[sel]
  - ready_o[sel] = mac_ready_i
  - A transfer occurs when mac_valid_o and mac_ready_i are both high. The counter increments only on a transfer.
- SEND exit:
  - If the transfer is at count==len-1 and no pad is needed, mac_last_o=1. Then pulse done_o[sel], rotate rr pointer to the other channel, go to IFG.
  - If the transfer is at count==len-1 and len<MIN_LEN with padding enabled, mac_last_o stays 0. Next state is PAD.
- PAD: mac_valid_o=1, mac_data_o=8'h00, ready_o=0. Counter continues from len. mac_last_o=1 on count==MIN_LEN-1. done_o pulses on that final transfer. Next state is IFG.
- MAC stall: with mac_ready_i=0, mac_data_o, mac_valid_o and mac_last_o hold stable. The source keeps its byte because ready_o is low.
- IFG: counts IFG_CYCLES cycles with all outputs idle and grant_o=0, then returns to IDLE. Requests seen during IFG wait; they are not lost.
- Requests during a frame:
  - Deassertion of req_i mid-frame is ignored; the frame runs to its latched length.
  - len_i changes after grant are ignored.
- Reset mid-frame: asynchronous return to IDLE with all outputs at reset values. The partial frame is abandoned and no done_o pulse is issued.
- Width: the counter is LEN_W bits. len values >= 2^LEN_W-1 are not supported.

Optional Feature:
TX_PAD_EN
- Defined: PAD state present. Frames shorter than MIN_LEN are extended with 8'h00 bytes. len==0 produces MIN_LEN pad bytes.
- Undefined: PAD state removed. mac_last_o is always asserted at len-1. len==0 is handled as a zero-length request (see Behaviour).

Decomposition:
- Shared package eth_tx_pkg:
  - FSM state enum tx_arb_state_t
  - constants ETH_MIN_LEN=60, ETH_IFG=12
  - channel-index typedef
- Natural sub-module: rr_arbiter2. Inputs req[1:0], ptr, en. Output one-hot gnt. Reused later for the RX side.

Test Plan:
- ch0 req with len=64, mac_ready_i=1, bytes 0..63: 64 transfers, mac_last_o on byte 63, done_o[0] pulse, then 12 idle cycles.
- Both requesting, len=64 each, after reset: ch0 served first, then ch1, then ch0 again, with no overlap on grant_o.
- TX_PAD_EN defined, len=10: 10 source bytes, then 50 bytes of 8'h00, mac_last_o on the 60th transfer, ready_o low during PAD.
- mac_ready_i held low 5 cycles mid-frame: mac_data_o stays stable; no byte lost or duplicated; final count is 64.
- rst asserted at byte 30: outputs reset immediately, no done_o; the next request restarts from byte 0 with ch0 priority.
- len=0 without TX_PAD_EN: done_o pulse, mac_valid_o never asserted, IFG entered.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared TX-side types and constants: arbiter FSM states, channel index and
// Ethernet framing constants used by the TX frame arbiter and its arbiter.
package eth_tx_pkg;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_IFG     = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2,
        ST_IFG  = 2'd3
    } tx_arb_state_t;

    typedef logic ch_idx_t;

    function automatic logic [1:0] ch_onehot(input ch_idx_t ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

    function automatic ch_idx_t ch_index(input logic [1:0] oh);
        return ch_idx_t'(oh[1]);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: a lone request wins outright, a tie goes
// to the channel named by ptr. Purely combinational, one-hot grant.
module rr_arbiter2
    import eth_tx_pkg::*;
(
    input  logic [1:0] req,
    input  ch_idx_t    ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    // Grant selection
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ch_onehot(ptr);
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin TX frame arbiter between two sources feeding one MAC byte port,
// with last-byte marking, inter-frame gap and optional short-frame padding (TX_PAD_EN).
module tx_frame_arbiter
    import eth_tx_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int MIN_LEN    = ETH_MIN_LEN,
    parameter int IFG_CYCLES = ETH_IFG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_i,
    input  logic [2*LEN_W-1:0] len_i,
    input  logic [15:0]        data_i,
    input  logic [1:0]         valid_i,
    output logic [1:0]         ready_o,
    output logic [1:0]         grant_o,
    output logic [1:0]         done_o,
    output logic [7:0]         mac_data_o,
    output logic               mac_valid_o,
    output logic               mac_last_o,
    input  logic               mac_ready_i,
    output logic               busy_o
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    tx_arb_state_t    state_q, state_d;
    ch_idx_t          rr_ptr_q, rr_ptr_d;
    ch_idx_t          sel_q, sel_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q, done_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;

    logic [1:0]       arb_gnt_s;
    ch_idx_t          arb_idx_s;
    logic [LEN_W-1:0] req_len_s;
    logic             last_data_s;
    logic             pad_needed_s;

    rr_arbiter2 u_rr_arbiter2 (
        .req (req_i),
        .ptr (rr_ptr_q),
        .en  (state_q == ST_IDLE),
        .gnt (arb_gnt_s)
    );

    assign arb_idx_s   = ch_index(arb_gnt_s);
    assign req_len_s   = arb_idx_s ? len_i[2*LEN_W-1:LEN_W] : len_i[LEN_W-1:0];
    assign last_data_s = (cnt_q == (len_q - LEN_W'(1)));
`ifdef TX_PAD_EN
    assign pad_needed_s = (len_q < LEN_W'(MIN_LEN));
`else
    assign pad_needed_s = 1'b0;
`endif

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != ST_IDLE);

    // Next-state, counters and the zero-latency MAC-side datapath
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        grant_d     = grant_q;
        done_d      = 2'b00;
        ifg_d       = ifg_q;
        ready_o     = 2'b00;
        mac_data_o  = 8'h00;
        mac_valid_o = 1'b0;
        mac_last_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    sel_d = arb_idx_s;
                    len_d = req_len_s;
                    cnt_d = {LEN_W{1'b0}};
                    if (req_len_s == {LEN_W{1'b0}}) begin
`ifdef TX_PAD_EN
                        grant_d = arb_gnt_s;
                        state_d = ST_PAD;
`else
                        // Nothing to send: report completion and still honour the gap.
                        done_d   = arb_gnt_s;
                        rr_ptr_d = ~arb_idx_s;
                        ifg_d    = {IFG_W{1'b0}};
                        state_d  = ST_IFG;
`endif
                    end else begin
                        grant_d = arb_gnt_s;
                        state_d = ST_SEND;
                    end
                end else begin
                    grant_d = 2'b00;
                end
            end

            ST_SEND: begin
                mac_data_o  = sel_q ? data_i[15:8] : data_i[7:0];
                mac_valid_o = valid_i[sel_q];
                ready_o     = mac_ready_i ? ch_onehot(sel_q) : 2'b00;
                mac_last_o  = last_data_s && !pad_needed_s;
                if (valid_i[sel_q] && mac_ready_i) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_data_s && pad_needed_s) begin
                        state_d = ST_PAD;
                    end else if (last_data_s) begin
                        done_d   = grant_q;
                        grant_d  = 2'b00;
                        rr_ptr_d = ~sel_q;
                        ifg_d    = {IFG_W{1'b0}};
                        state_d  = ST_IFG;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_PAD: begin
`ifdef TX_PAD_EN
                mac_valid_o = 1'b1;
                mac_last_o  = (cnt_q == LEN_W'(MIN_LEN - 1));
                if (mac_ready_i) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == LEN_W'(MIN_LEN - 1)) begin
                        done_d   = grant_q;
                        grant_d  = 2'b00;
                        rr_ptr_d = ~sel_q;
                        ifg_d    = {IFG_W{1'b0}};
                        state_d  = ST_IFG;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
`else
                grant_d = 2'b00;
                state_d = ST_IDLE;
`endif
            end

            ST_IFG: begin
                grant_d = 2'b00;
                if (ifg_q == IFG_W'(IFG_CYCLES - 1)) begin
                    ifg_d   = {IFG_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + IFG_W'(1);
                end
            end

            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            sel_q    <= 1'b0;
            cnt_q    <= {LEN_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            ifg_q    <= {IFG_W{1'b0}};
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            ifg_q    <= ifg_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed self-checking bench for tx_frame_arbiter; covers both builds
// (with and without TX_PAD_EN).
module tb_tx_frame_arbiter;

    localparam int LEN_W      = 16;
    localparam int MIN_LEN    = 60;
    localparam int IFG_CYCLES = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_i;
    logic [2*LEN_W-1:0] len_i;
    logic [15:0]        data_i;
    logic [1:0]         valid_i;
    logic [1:0]         ready_o;
    logic [1:0]         grant_o;
    logic [1:0]         done_o;
    logic [7:0]         mac_data_o;
    logic               mac_valid_o;
    logic               mac_last_o;
    logic               mac_ready_i;
    logic               busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_frame_arbiter #(
        .LEN_W      (LEN_W),
        .MIN_LEN    (MIN_LEN),
        .IFG_CYCLES (IFG_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .len_i       (len_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .grant_o     (grant_o),
        .done_o      (done_o),
        .mac_data_o  (mac_data_o),
        .mac_valid_o (mac_valid_o),
        .mac_last_o  (mac_last_o),
        .mac_ready_i (mac_ready_i),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(input int ch, input int k);
        logic [7:0] b;
        b = 8'(k);
        return (ch == 1) ? (b ^ 8'hA5) : b;
    endfunction

    task automatic chk_all_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd0);
        chk({tag, "_mvalid"}, 32'(mac_valid_o), 32'd0);
        chk({tag, "_mlast"}, 32'(mac_last_o), 32'd0);
        chk({tag, "_mdata"}, 32'(mac_data_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    // Called at the negedge of the grant cycle; plays the source and checks every MAC byte.
    task automatic do_frame(input int ch, input int len, input int stall_at,
                            input int stall_n, input int rst_at);
        int k = 0;
        int total;
        int stalled = 0;
        int guard = 0;
        logic [1:0] oh;
        logic [7:0] exp_data;
        oh = (ch == 1) ? 2'b10 : 2'b01;
        total = len;
`ifdef TX_PAD_EN
        if (len < MIN_LEN) total = MIN_LEN;
`endif
        while (k < total && guard < total + stall_n + 8) begin
            data_i  = (ch == 1) ? {src_byte(1, k), 8'hEE} : {8'hEE, src_byte(0, k)};
            valid_i = oh;
            if (k == stall_at && stalled < stall_n) begin
                mac_ready_i = 1'b0;
                stalled++;
            end else begin
                mac_ready_i = 1'b1;
            end
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                chk_all_idle("rst_mid");
                return;
            end
            #1;
            exp_data = (k < len) ? src_byte(ch, k) : 8'h00;
            chk("grant", 32'(grant_o), 32'(oh));
            chk("mac_valid", 32'(mac_valid_o), 32'd1);
            chk("mac_data", 32'(mac_data_o), 32'(exp_data));
            chk("mac_last", 32'(mac_last_o), 32'(k == total - 1));
            chk("ready", 32'(ready_o), (mac_ready_i && k < len) ? 32'(oh) : 32'd0);
            chk("done_early", 32'(done_o), 32'd0);
            if (mac_ready_i) k++;
            guard++;
            @(negedge clk);
        end
        chk("frame_len", 32'(k), 32'(total));
        mac_ready_i = 1'b1;
        valid_i     = 2'b00;
        #1;
        chk("done_pulse", 32'(done_o), 32'(oh));
        chk("grant_drop", 32'(grant_o), 32'd0);
        chk("valid_drop", 32'(mac_valid_o), 32'd0);
        chk("busy_ifg", 32'(busy_o), 32'd1);
    endtask

    // Remaining IFG cycles after the done cycle, then one IDLE cycle.
    task automatic wait_ifg();
        for (int i = 1; i < IFG_CYCLES; i++) begin
            @(negedge clk);
            #1;
            chk("ifg_busy", 32'(busy_o), 32'd1);
            chk("ifg_grant", 32'(grant_o), 32'd0);
            chk("ifg_valid", 32'(mac_valid_o), 32'd0);
            chk("ifg_done", 32'(done_o), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("ifg_exit_busy", 32'(busy_o), 32'd0);
        chk("ifg_exit_grant", 32'(grant_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        req_i       = 2'b00;
        len_i       = '0;
        data_i      = 16'h0000;
        valid_i     = 2'b00;
        mac_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_idle("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single ch0 frame of 64; req drop and len change after grant are ignored
        @(negedge clk);
        req_i = 2'b01;
        len_i = {16'd0, 16'd64};
        #1;
        chk("grant_latency", 32'(grant_o), 32'd0);
        @(negedge clk);
        req_i = 2'b00;
        len_i = {16'd0, 16'd5};
        do_frame(0, 64, -1, 0, -1);
        wait_ifg();

        // Both requesting from reset: ch0, ch1, ch0
        do_reset();
        req_i = 2'b11;
        len_i = {16'd64, 16'd64};
        @(negedge clk);
        do_frame(0, 64, -1, 0, -1);
        wait_ifg();
        @(negedge clk);
        do_frame(1, 64, -1, 0, -1);
        wait_ifg();
        @(negedge clk);
        do_frame(0, 64, -1, 0, -1);
        req_i = 2'b00;
        wait_ifg();

        // MAC stall of 5 cycles at byte 20
        req_i = 2'b01;
        len_i = {16'd0, 16'd64};
        @(negedge clk);
        req_i = 2'b00;
        do_frame(0, 64, 20, 5, -1);
        wait_ifg();

        // Reset at byte 30 of a ch1 frame, then tie restarts with ch0
        req_i = 2'b10;
        len_i = {16'd64, 16'd0};
        @(negedge clk);
        req_i = 2'b00;
        do_frame(1, 64, -1, 0, 30);
        @(negedge clk);
        #1;
        chk("rst_hold_done", 32'(done_o), 32'd0);
        chk("rst_hold_busy", 32'(busy_o), 32'd0);
        rst   = 1'b1;
        req_i = 2'b11;
        len_i = {16'd8, 16'd8};
        @(negedge clk);
        req_i = 2'b00;
        do_frame(0, 8, -1, 0, -1);
        wait_ifg();

        // Short frame of 10 (padded to MIN_LEN when padding is built in)
        req_i = 2'b01;
        len_i = {16'd0, 16'd10};
        @(negedge clk);
        req_i = 2'b00;
        do_frame(0, 10, -1, 0, -1);
        wait_ifg();

        // Zero-length request
        req_i = 2'b01;
        len_i = '0;
`ifdef TX_PAD_EN
        @(negedge clk);
        req_i = 2'b00;
        do_frame(0, 0, -1, 0, -1);
        wait_ifg();
`else
        @(negedge clk);
        req_i = 2'b00;
        #1;
        chk("zero_done", 32'(done_o), 32'd1);
        chk("zero_grant", 32'(grant_o), 32'd0);
        chk("zero_valid", 32'(mac_valid_o), 32'd0);
        chk("zero_busy", 32'(busy_o), 32'd1);
        wait_ifg();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
